vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//   Source end of the vga_if link: generates VGA hs/vs timing and pixel coordinates, and takes
//   colour back from a renderer with fixed 1-cycle latency. Drives one vga_if, e.g. one vga_mux input.
//   Output sync, active flag and colour are registered and mutually aligned. Default mode 640x480@60 (25.175 MHz pixel clock).
// PARAMETERS
//   H_ACTIVE 640  visible pixels per line
//   H_FP     16   horizontal front porch, pixels
//   H_SYNC   96   hs pulse width, pixels
//   H_BP     48   horizontal back porch, pixels
//   V_ACTIVE 480  visible lines per frame
//   V_FP     10   vertical front porch, lines
//   V_SYNC   2    vs pulse width, lines
//   V_BP     33   vertical back porch, lines
//   HS_POL   0    hs asserted level (0 = active-low)
//   VS_POL   0    vs asserted level (0 = active-low)
//   COLOR_W  4    bits per colour channel; equals the vga_if channel width
// PORTS
//   clk_i          in   1        pixel clock
//   rst_n_i        in   1        asynchronous active-low reset
//   en_i           in   1        timing enable; low = synchronous restart and blank
//   red_i          in   COLOR_W  renderer red for the pixel presented the previous cycle
//   green_i        in   COLOR_W  renderer green, same timing
//   blue_i         in   COLOR_W  renderer blue, same timing
//   pix_x_o        out  XW       current column, XW = $clog2(H_TOTAL)
//   pix_y_o        out  YW       current line, YW = $clog2(V_TOTAL)
//   pix_act_o      out  1        pix_x_o/pix_y_o inside the visible area
//   line_start_o   out  1        1-cycle pulse at h_cnt==0
//   frame_start_o  out  1        1-cycle pulse at h_cnt==0 && v_cnt==0
//   vga_out_if     vga_if        hs, vs, red, green, blue to the monitor or mux
// BEHAVIOUR
//   - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
//   - Counters, all while en_i=1:
//     - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
//     - v_cnt increments only on the h wrap cycle; wraps V_TOTAL-1 -> 0 on the same cycle as h.
//   - Stage 0, combinational from the counter regs:
//     - pix_x_o=h_cnt, pix_y_o=v_cnt.
//     - pix_act_o = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE).
//     - line_start_o and frame_start_o decode from the same regs.
//   - hs region: h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751).
//   - vs region: v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491), for whole lines.
//   - Stage 1, registered: hs/vs/act are delayed 1 cycle to align with red_i/green_i/blue_i.
//     - vga_out_if.hs = HS_POL when in the hs region, else ~HS_POL. vs likewise with VS_POL.
//     - Colour = inputs when the delayed act=1, else 0. Blanking is always enforced; the renderer is not trusted.
//   - Total latency: counter value -> pin = 1 cycle for sync and colour alike.
//   - Reset (rst_n_i=0, async):
//     - h_cnt=0, v_cnt=0.
//     - hs=~HS_POL, vs=~VS_POL, colour=0.
//     - pix_act_o=1 and frame_start_o=1 combinationally, since the counters sit at 0,0.
//   - en_i=0, sampled synchronously:
//     - Counters forced to 0 next edge.
//     - Stage 1 outputs forced inactive: sync deasserted, colour 0.
//     - pix_act_o, line_start_o and frame_start_o forced 0.
//     - On en_i rising, the first enabled cycle is (0,0) with frame_start_o=1. A mid-frame drop therefore restarts the frame cleanly.
//   - Elaboration $error if any porch/sync parameter is 0, or COLOR_W != the vga_if width.
// STRUCTURE
//   - vga_pkg holds:
//     - typedef vga_timing_t {active, fp, sync, bp}
//     - function total(vga_timing_t)
//     - localparam VGA_640x480 timing constants
//   - Sub-module vga_axis_cnt:
//     - Parameterised by vga_timing_t; inputs step_i and clr_i.
//     - Outputs cnt_o, wrap_o, act_o, sync_o.
//     - Instantiated twice: h stepped every cycle; v stepped by h wrap_o.
//   - The top holds the stage-1 registers and the vga_if drive.
// TESTING
//   - Reset then en_i=1 -> sync pins at inactive level, colour 0, frame_start_o=1 on the first cycle.
//   - Line timing, defaults:
//     - hs pin asserted for exactly 96 cycles.
//     - Starts 657 cycles after line_start_o, pin latency +1.
//     - line_start_o period exactly 800.
//   - Frame timing:
//     - vs asserted for exactly 2 lines (1600 cycles), beginning at line 490.
//     - frame_start_o period 420000 cycles.
//   - Colour alignment: drive red_i = pix_x_o[3:0] registered 1 cycle by the bench.
//     - Pin red equals (x mod 16) for every active pixel.
//     - Exactly 640x480 nonzero-capable pixels per frame; all zero in blanking.
//   - Renderer drives all-ones constantly -> every blanking pixel still outputs 0 on all channels.
//   - Override H=8/2/2/2, V=4/1/1/1:
//     - Drop en_i at (5,2) -> outputs inactive the next cycle.
//     - Re-raise en_i -> restart at (0,0) with frame_start_o.
//     - Async reset mid-line returns all outputs to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_pkg - per-axis VGA timing descriptor and 640x480@60 constants     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package vga_pkg;

  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
  } vga_timing_t;

  function automatic int unsigned total(vga_timing_t t);
    return 32'(t.active) + 32'(t.fp) + 32'(t.sync) + 32'(t.bp);
  endfunction

  localparam vga_timing_t VGA_640X480_H = '{active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48};
  localparam vga_timing_t VGA_640X480_V = '{active: 16'd480, fp: 16'd10, sync: 16'd2,  bp: 16'd33};

endpackage
`default_nettype wire

// File: rtl/vga_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_if - monitor-side VGA link: sync pair plus RGB channels           |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface vga_if #(
  parameter int COLOR_W = 4
);
  logic               hs;
  logic               vs;
  logic [COLOR_W-1:0] red;
  logic [COLOR_W-1:0] green;
  logic [COLOR_W-1:0] blue;

  modport src (output hs, vs, red, green, blue);
  modport snk (input  hs, vs, red, green, blue);
endinterface
`default_nettype wire

// File: rtl/vga_axis_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_axis_cnt - one timing axis: wrapping position counter + decodes   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter vga_timing_t TIMING = VGA_640X480_H,
  parameter int          CW     = 10
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          step_i,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o,
  output logic          wrap_o,
  output logic          act_o,
  output logic          sync_o
);

  localparam int unsigned   TOTAL   = total(TIMING);
  localparam logic [CW-1:0] LAST    = CW'(TOTAL - 32'd1);
  localparam logic [CW-1:0] ACT_N   = CW'(32'(TIMING.active));
  localparam logic [CW-1:0] SYNC_LO = CW'(32'(TIMING.active) + 32'(TIMING.fp));
  localparam logic [CW-1:0] SYNC_HI = CW'(32'(TIMING.active) + 32'(TIMING.fp) + 32'(TIMING.sync) - 32'd1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign wrap_o = step_i && (cnt_q == LAST);
  assign cnt_o  = cnt_q;
  assign act_o  = (cnt_q < ACT_N);
  assign sync_o = (cnt_q >= SYNC_LO) && (cnt_q <= SYNC_HI);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || wrap_o) begin
      cnt_d = '0;
    end else if (step_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_timing_gen - VGA sync/coordinate source with 1-cycle colour return |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = int'(VGA_640X480_H.active),
  parameter int   H_FP     = int'(VGA_640X480_H.fp),
  parameter int   H_SYNC   = int'(VGA_640X480_H.sync),
  parameter int   H_BP     = int'(VGA_640X480_H.bp),
  parameter int   V_ACTIVE = int'(VGA_640X480_V.active),
  parameter int   V_FP     = int'(VGA_640X480_V.fp),
  parameter int   V_SYNC   = int'(VGA_640X480_V.sync),
  parameter int   V_BP     = int'(VGA_640X480_V.bp),
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   COLOR_W  = 4,
  localparam int  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  XW       = $clog2(H_TOTAL),
  localparam int  YW       = $clog2(V_TOTAL)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               en_i,
  input  logic [COLOR_W-1:0] red_i,
  input  logic [COLOR_W-1:0] green_i,
  input  logic [COLOR_W-1:0] blue_i,
  output logic [XW-1:0]      pix_x_o,
  output logic [YW-1:0]      pix_y_o,
  output logic               pix_act_o,
  output logic               line_start_o,
  output logic               frame_start_o,
  vga_if.src                 vga_out_if
);

  generate
    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
      $error("vga_timing_gen: porch and sync widths must all be nonzero");
    end
    if (COLOR_W != vga_out_if.COLOR_W) begin : g_bad_width
      $error("vga_timing_gen: COLOR_W does not match the vga_if channel width");
    end
  endgenerate

  localparam vga_timing_t H_TIMING = '{active: 16'(H_ACTIVE), fp: 16'(H_FP), sync: 16'(H_SYNC), bp: 16'(H_BP)};
  localparam vga_timing_t V_TIMING = '{active: 16'(V_ACTIVE), fp: 16'(V_FP), sync: 16'(V_SYNC), bp: 16'(V_BP)};

  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;
  logic          h_wrap, h_act, h_sync;
  logic          v_wrap_unused, v_act, v_sync;
  logic          pix_act;

  vga_axis_cnt #(.TIMING(H_TIMING), .CW(XW)) u_h_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .step_i  (en_i),
    .clr_i   (~en_i),
    .cnt_o   (h_cnt),
    .wrap_o  (h_wrap),
    .act_o   (h_act),
    .sync_o  (h_sync)
  );

  // Lines advance only on the horizontal wrap, so both axes wrap together.
  vga_axis_cnt #(.TIMING(V_TIMING), .CW(YW)) u_v_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .step_i  (h_wrap),
    .clr_i   (~en_i),
    .cnt_o   (v_cnt),
    .wrap_o  (v_wrap_unused),
    .act_o   (v_act),
    .sync_o  (v_sync)
  );

  assign pix_act       = en_i && h_act && v_act;
  assign pix_x_o       = h_cnt;
  assign pix_y_o       = v_cnt;
  assign pix_act_o     = pix_act;
  assign line_start_o  = en_i && (h_cnt == '0);
  assign frame_start_o = en_i && (h_cnt == '0) && (v_cnt == '0);

  logic hs_q, hs_d;
  logic vs_q, vs_d;
  logic act_q, act_d;

  always_comb begin
    hs_d  = ~HS_POL;
    vs_d  = ~VS_POL;
    act_d = 1'b0;
    if (en_i) begin
      hs_d  = h_sync ? HS_POL : ~HS_POL;
      vs_d  = v_sync ? VS_POL : ~VS_POL;
      act_d = pix_act;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      act_q <= 1'b0;
    end else begin
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      act_q <= act_d;
    end
  end

  // Renderer colour arrives one cycle after its pixel, already aligned with act_q.
  assign vga_out_if.hs    = hs_q;
  assign vga_out_if.vs    = vs_q;
  assign vga_out_if.red   = act_q ? red_i   : '0;
  assign vga_out_if.green = act_q ? green_i : '0;
  assign vga_out_if.blue  = act_q ? blue_i  : '0;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vga_timing_gen - default 640x480 and tiny-mode generator benches   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_vga_timing_gen;

  typedef struct {
    int x, y;
    bit act, ls, fs, hs, vs;
    int r, g, b;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en_d, en_s, ones, chk_on;
  int   n_assert = 0;
  int   n_fail   = 0;

  logic [3:0] rd, gd, bd, rs, gs, bs;
  logic [9:0] x_d, y_d;
  logic [3:0] x_s;
  logic [2:0] y_s;
  logic act_d, ls_d, fs_d, act_s, ls_s, fs_s;

  vga_if #(.COLOR_W(4)) if_d ();
  vga_if #(.COLOR_W(4)) if_s ();

  vga_timing_gen u_def (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en_d),
    .red_i(rd), .green_i(gd), .blue_i(bd),
    .pix_x_o(x_d), .pix_y_o(y_d), .pix_act_o(act_d),
    .line_start_o(ls_d), .frame_start_o(fs_d), .vga_out_if(if_d)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .COLOR_W(4)
  ) u_small (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en_s),
    .red_i(rs), .green_i(gs), .blue_i(bs),
    .pix_x_o(x_s), .pix_y_o(y_s), .pix_act_o(act_s),
    .line_start_o(ls_s), .frame_start_o(fs_s), .vga_out_if(if_s)
  );

  // Renderers: colour for the pixel presented on the previous cycle.
  always @(posedge clk) begin
    rd <= ones ? 4'hF : x_d[3:0];
    gd <= ones ? 4'hF : y_d[3:0];
    bd <= ones ? 4'hF : ~x_d[3:0];
    rs <= ones ? 4'hF : x_s;
    gs <= ones ? 4'hF : {1'b0, y_s};
    bs <= ones ? 4'hF : ~x_s;
  end

  // Model state: enabled cycles since the last restart, and the pixel one cycle back.
  int n_dm, s1n_d, n_sm, s1n_s;
  bit s1v_d, s1v_s, s1o;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_dm <= 0; s1n_d <= 0; s1v_d <= 1'b0;
      n_sm <= 0; s1n_s <= 0; s1v_s <= 1'b0;
    end else begin
      if (en_d) begin s1v_d <= 1'b1; s1n_d <= n_dm; n_dm <= n_dm + 1; end
      else      begin s1v_d <= 1'b0; n_dm <= 0; end
      if (en_s) begin s1v_s <= 1'b1; s1n_s <= n_sm; n_sm <= n_sm + 1; end
      else      begin s1v_s <= 1'b0; n_sm <= 0; end
    end
  end
  always @(posedge clk) s1o <= ones;

  function automatic exp_t model(int n, bit en, int s1n, bit s1v, bit s1ones,
                                 int ha, int hf, int hw, int hb,
                                 int va, int vf, int vw, int vb, bit hp, bit vp);
    exp_t e;
    int ht, vt, px, py;
    bit a1;
    ht = ha + hf + hw + hb;
    vt = va + vf + vw + vb;
    e.x   = n % ht;
    e.y   = (n / ht) % vt;
    e.act = en && (e.x < ha) && (e.y < va);
    e.ls  = en && (e.x == 0);
    e.fs  = e.ls && (e.y == 0);
    px = s1n % ht;
    py = (s1n / ht) % vt;
    e.hs = (s1v && px >= ha + hf && px < ha + hf + hw) ? hp : !hp;
    e.vs = (s1v && py >= va + vf && py < va + vf + vw) ? vp : !vp;
    a1   = s1v && (px < ha) && (py < va);
    e.r  = !a1 ? 0 : (s1ones ? 15 : px % 16);
    e.g  = !a1 ? 0 : (s1ones ? 15 : py % 16);
    e.b  = !a1 ? 0 : (s1ones ? 15 : 15 - (px % 16));
    return e;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (chk_on) begin
      e = model(n_dm, en_d, s1n_d, s1v_d, s1o, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
      chk("def_x", int'(x_d), e.x);          chk("def_y", int'(y_d), e.y);
      chk("def_act", int'(act_d), int'(e.act));
      chk("def_ls", int'(ls_d), int'(e.ls)); chk("def_fs", int'(fs_d), int'(e.fs));
      chk("def_hs", int'(if_d.hs), int'(e.hs)); chk("def_vs", int'(if_d.vs), int'(e.vs));
      chk("def_red", int'(if_d.red), e.r);   chk("def_green", int'(if_d.green), e.g);
      chk("def_blue", int'(if_d.blue), e.b);
      e = model(n_sm, en_s, s1n_s, s1v_s, s1o, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b0);
      chk("sm_x", int'(x_s), e.x);           chk("sm_y", int'(y_s), e.y);
      chk("sm_act", int'(act_s), int'(e.act));
      chk("sm_ls", int'(ls_s), int'(e.ls));  chk("sm_fs", int'(fs_s), int'(e.fs));
      chk("sm_hs", int'(if_s.hs), int'(e.hs)); chk("sm_vs", int'(if_s.vs), int'(e.vs));
      chk("sm_red", int'(if_s.red), e.r);    chk("sm_green", int'(if_s.green), e.g);
      chk("sm_blue", int'(if_s.blue), e.b);
    end
  end

  initial begin
    int t_ls1, t_hf, t_hr, t_fs1, t_vf, t_vr, shs, cnt_d1, cnt_s1;
    bit found;
    rst_n = 1'b0; en_d = 1'b0; en_s = 1'b0; ones = 1'b0; chk_on = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_on = 1'b1;

    // Reset values with the counters parked at (0,0).
    @(negedge clk); #2;
    en_d = 1'b1; en_s = 1'b1;
    #1;
    chk("rst_def_act", int'(act_d), 1);   chk("rst_def_fs", int'(fs_d), 1);
    chk("rst_def_hs", int'(if_d.hs), 1);  chk("rst_def_vs", int'(if_d.vs), 1);
    chk("rst_def_red", int'(if_d.red), 0); chk("rst_sm_hs", int'(if_s.hs), 0);
    en_d = 1'b0; en_s = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Enable: first cycle is (0,0) with frame_start.
    #2 en_d = 1'b1; en_s = 1'b1; ones = 1'b0;
    #1;
    chk("en_def_fs", int'(fs_d), 1);  chk("en_def_x", int'(x_d), 0);
    chk("en_def_hs", int'(if_d.hs), 1); chk("en_def_vs", int'(if_d.vs), 1);
    chk("en_def_red", int'(if_d.red), 0); chk("en_sm_fs", int'(fs_s), 1);

    t_ls1 = -1; t_hf = -1; t_hr = -1; t_fs1 = -1; t_vf = -1; t_vr = -1; shs = 0;
    for (int c = 1; c <= 1700; c++) begin
      @(negedge clk); #1;
      if (ls_d && t_ls1 < 0) t_ls1 = c;
      if (!if_d.hs && t_hf < 0) t_hf = c;
      if (if_d.hs && t_hf >= 0 && t_hr < 0) t_hr = c;
      if (fs_s && t_fs1 < 0) t_fs1 = c;
      if (!if_s.vs && t_vf < 0) t_vf = c;
      if (if_s.vs && t_vf >= 0 && t_vr < 0) t_vr = c;
      if (c <= 14 && if_s.hs) shs++;
    end
    chk("def_line_period", t_ls1, 800);
    chk("def_hs_start", t_hf, 657);
    chk("def_hs_width", t_hr - t_hf, 96);
    chk("sm_frame_period", t_fs1, 98);
    chk("sm_vs_start", t_vf, 71);
    chk("sm_vs_width", t_vr - t_vf, 14);
    chk("sm_hs_width", shs, 2);

    // All-ones renderer: only visible pixels may carry colour.
    #1 ones = 1'b1;
    repeat (2) @(negedge clk);
    cnt_d1 = 0; cnt_s1 = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk); #1;
      if (if_d.red != 0 || if_d.green != 0 || if_d.blue != 0) cnt_d1++;
      if (c < 98 && (if_s.red != 0 || if_s.green != 0 || if_s.blue != 0)) cnt_s1++;
    end
    chk("def_lit_pixels_line", cnt_d1, 640);
    chk("sm_lit_pixels_frame", cnt_s1, 32);

    // Drop enable mid-frame at (5,2).
    found = 1'b0;
    for (int c = 0; c < 120 && !found; c++) begin
      @(negedge clk); #1;
      if (x_s == 4'd5 && y_s == 3'd2) found = 1'b1;
    end
    chk("sm_find_5_2", int'(found), 1);
    #1 en_s = 1'b0;
    @(negedge clk); #1;
    chk("drop_x", int'(x_s), 0);     chk("drop_y", int'(y_s), 0);
    chk("drop_act", int'(act_s), 0); chk("drop_ls", int'(ls_s), 0);
    chk("drop_fs", int'(fs_s), 0);   chk("drop_hs", int'(if_s.hs), 0);
    chk("drop_vs", int'(if_s.vs), 1); chk("drop_red", int'(if_s.red), 0);
    chk("drop_blue", int'(if_s.blue), 0);
    repeat (3) @(negedge clk);
    #2 en_s = 1'b1;
    #1;
    chk("reen_fs", int'(fs_s), 1); chk("reen_x", int'(x_s), 0);
    chk("reen_y", int'(y_s), 0);   chk("reen_act", int'(act_s), 1);
    @(negedge clk); #1;
    chk("reen_x_next", int'(x_s), 1);

    // Asynchronous reset mid-line, no clock edge in between.
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (x_s == 4'd3) found = 1'b1;
      else begin @(negedge clk); #1; end
    end
    chk("sm_find_x3", int'(found), 1);
    chk("pre_rst_red", int'(if_s.red), 15);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_x", int'(x_s), 0);        chk("arst_y", int'(y_s), 0);
    chk("arst_hs", int'(if_s.hs), 0);   chk("arst_vs", int'(if_s.vs), 1);
    chk("arst_red", int'(if_s.red), 0); chk("arst_green", int'(if_s.green), 0);
    chk("arst_act", int'(act_s), 1);    chk("arst_fs", int'(fs_s), 1);
    chk("arst_def_x", int'(x_d), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
